instruction_fetch_stage: RTL and testbench

IF stage of the 5-stage MIPS pipeline and the initiator side of the instruction memory. It owns the program counter and drives the word-aligned byte address into the combinational instruction memory. It captures the returned word into the IF/ID pipeline register. It honours stall requests from the hazard unit and flush/redirect requests from branch resolution.

---
 rtl/instruction_fetch_stage.sv | 118 +++++++++++
 tb/tb_instruction_fetch_stage.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_stage.sv
// MIPS IF stage: owns the PC, drives the instruction memory address and captures IF/ID.
// Optional macro IF_PC_WRAP_EN confines the PC to the IM_BYTES instruction memory window.
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned IM_BYTES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic [31:0] im_data,
  output logic [31:0] im_addr,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid
);

  // state      | meaning
  // RESET_FILL | first cycle after reset: RESET_PC is presented, IF/ID stays a bubble
  // RUN        | normal fetch with stall / flush / redirect handling
  typedef enum logic {
    S_RESET_FILL = 1'b0,
    S_RUN        = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  logic [31:0] pc_plus4;
  logic [31:0] seq_pc;
  logic [31:0] tgt_pc;
  logic        unused_tgt_low;

  if (RESET_PC[1:0] != 2'b00) begin : g_bad_reset_pc
    $error("RESET_PC must be word-aligned");
  end

  assign pc_plus4       = pc_q + 32'd4;
  assign unused_tgt_low = ^redirect_pc[1:0];

`ifdef IF_PC_WRAP_EN
  localparam logic [31:0] PC_MASK = 32'(IM_BYTES - 1);

  if ((IM_BYTES < 4) || ((IM_BYTES & (IM_BYTES - 1)) != 0)) begin : g_bad_im_bytes
    $error("IM_BYTES must be a power of two of at least 4");
  end

  assign seq_pc = pc_plus4 & PC_MASK;
  assign tgt_pc = {redirect_pc[31:2], 2'b00} & PC_MASK;
`else
  if ((IM_BYTES < 4) || ((IM_BYTES & (IM_BYTES - 1)) != 0)) begin : g_bad_im_bytes
    $error("IM_BYTES must be a power of two of at least 4");
  end

  assign seq_pc = pc_plus4;
  assign tgt_pc = {redirect_pc[31:2], 2'b00};
`endif

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    case (state_q)
      S_RESET_FILL: begin
        state_d = S_RUN;
        instr_d = 32'h0000_0000;
        pc4_d   = 32'h0000_0000;
        valid_d = 1'b0;
      end
      default: begin
        if (redirect)   pc_d = tgt_pc;
        else if (!stall) pc_d = seq_pc;

        // redirect squashes the wrong-path word fetched this cycle
        if (redirect || flush) begin
          instr_d = 32'h0000_0000;
          pc4_d   = 32'h0000_0000;
          valid_d = 1'b0;
        end else if (!stall) begin
          instr_d = im_data;
          pc4_d   = pc_plus4;
          valid_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RESET_FILL;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0000_0000;
      pc4_q   <= 32'h0000_0000;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign pc          = pc_q;
  assign im_addr     = pc_q;
  assign if_id_instr = instr_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_valid = valid_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Self-checking bench for instruction_fetch_stage: directed plan steps plus random control traffic
// compared against a cycle-level reference model of fetch / stall / flush / redirect.
module tb_instruction_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, redirect;
  logic [31:0] redirect_pc;
  logic [31:0] im_data, im_addr, pc, if_id_instr, if_id_pc4;
  logic        if_id_valid;

  logic [31:0] mem [1024];

  int checks = 0;
  int errors = 0;

  // reference model state
  logic        m_fill;
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;

  always #5 clk = ~clk;

  assign im_data = mem[im_addr[11:2]];

  instruction_fetch_stage #(.RESET_PC(32'h0), .IM_BYTES(4096)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .redirect(redirect),
    .redirect_pc(redirect_pc), .im_data(im_data), .im_addr(im_addr), .pc(pc),
    .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid)
  );

  function automatic logic [31:0] wrap(input logic [31:0] a);
`ifdef IF_PC_WRAP_EN
    return a % 32'd4096;
`else
    return a;
`endif
  endfunction

  function automatic logic [31:0] fetch_word(input logic [31:0] a);
    logic [9:0] idx;
    idx = a[11:2];
    return mem[idx];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".pc"}, pc, m_pc);
    chk({tag, ".im_addr"}, im_addr, m_pc);
    chk({tag, ".instr"}, if_id_instr, m_instr);
    chk({tag, ".pc4"}, if_id_pc4, m_pc4);
    chk({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, m_valid});
  endtask

  task automatic model_reset();
    m_fill = 1'b1; m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
  endtask

  // one clock with the given controls; model advanced from the architectural rules
  task automatic cyc(input logic s, input logic f, input logic r, input logic [31:0] rp,
                     input string tag);
    logic [31:0] old_pc;
    stall = s; flush = f; redirect = r; redirect_pc = rp;
    old_pc = m_pc;
    if (m_fill) begin
      m_fill = 1'b0;
      m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
    end else begin
      if (r)       m_pc = wrap((rp / 4) * 4);
      else if (!s) m_pc = wrap(old_pc + 32'd4);
      if (r || f) begin
        m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      end else if (!s) begin
        m_instr = fetch_word(old_pc); m_pc4 = old_pc + 32'd4; m_valid = 1'b1;
      end
    end
    @(posedge clk); #1;
    check_all(tag);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[0] = 32'h8C10_0004;
    mem[1] = 32'h0250_8820;

    rst_n = 1'b0; stall = 0; flush = 0; redirect = 0; redirect_pc = 32'h0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk); rst_n = 1'b1;

    // free run from reset: pc 0,0,4,8 then capture of the two directed words
    cyc(0, 0, 0, 0, "fill");
    chk("fill.valid0", {31'd0, if_id_valid}, 32'd0);
    cyc(0, 0, 0, 0, "run1");
    chk("run1.instr_const", if_id_instr, 32'h8C10_0004);
    chk("run1.pc4_const", if_id_pc4, 32'h4);
    cyc(0, 0, 0, 0, "run2");
    chk("run2.instr_const", if_id_instr, 32'h0250_8820);
    chk("run2.pc_const", pc, 32'h8);

    // stall 3 cycles at pc=8
    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, "stall");
    chk("stall.pc_const", pc, 32'h8);
    cyc(0, 0, 0, 0, "stall_rel");
    chk("stall_rel.pc4_const", if_id_pc4, 32'hC);
    cyc(0, 0, 0, 0, "to_10");

    // redirect with unaligned target at pc=10
    chk("redir.pc_pre", pc, 32'h10);
    cyc(0, 0, 1, 32'h0000_0043, "redir");
    chk("redir.pc_const", pc, 32'h40);
    cyc(0, 0, 0, 0, "redir_b");
    chk("redir_b.pc4_const", if_id_pc4, 32'h44);

    cyc(1, 0, 1, 32'h0000_0100, "redir_stall");
    cyc(0, 0, 0, 0, "after_rs");
    cyc(1, 1, 0, 0, "flush_stall");
    cyc(0, 1, 0, 0, "flush_only");
    cyc(0, 0, 0, 0, "after_flush");

    // random control traffic
    for (int i = 0; i < 300; i++) begin
      logic s, f, r;
      s = ($urandom_range(0, 3) == 0);
      f = ($urandom_range(0, 7) == 0);
      r = ($urandom_range(0, 9) == 0);
      cyc(s, f, r, $urandom_range(0, 32'h1FFF), "rand");
    end

    // wrap boundaries
    cyc(0, 0, 1, 32'h0000_0FFC, "to_ffc");
    cyc(0, 0, 0, 0, "past_ffc");
`ifdef IF_PC_WRAP_EN
    chk("wrap.ffc_const", pc, 32'h0);
`else
    chk("wrap.ffc_const", pc, 32'h1000);
`endif
    cyc(0, 0, 1, 32'hFFFF_FFFC, "to_top");
    cyc(0, 0, 0, 0, "past_top");
    chk("wrap.top_const", pc, 32'h0);

    // asynchronous reset mid-cycle at pc=20
    cyc(0, 0, 1, 32'h0000_0020, "to_20");
    cyc(1, 0, 0, 0, "hold_20");
    chk("async.pc_pre", pc, 32'h20);
    stall = 1; flush = 1; redirect = 1; redirect_pc = 32'h400;
    #2 rst_n = 1'b0;
    #1;
    chk("async.pc", pc, 32'h0);
    chk("async.valid", {31'd0, if_id_valid}, 32'd0);
    model_reset();
    check_all("async");
    stall = 0; flush = 0; redirect = 0;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, "post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
